exec_stub_gen: RTL and testbench

- Synthesizable, parametrised stand-in for the PDP-8 execute unit. Used for IFD unit-level and emulation runs.
- Watches the decoded opcode buses from the IFD. For each instruction it returns a new PC and holds stall for a pseudo-random or fixed number of cycles.
- After a programmable transaction count it sends base_addr as the final PC and raises done.
- Adds over the prior stimulus model: LFSR randomness, a selectable PC mode, a transaction counter output, and a done handshake.

---
 rtl/exec_stub_gen.sv | 176 +++++++++++++++++
 tb/tb_exec_stub_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stub_gen.sv
`default_nettype none
// ============================================================================
// Module      : exec_stub_gen
// Description : Stand-in for the PDP-8 execute unit. Watches the decoded
//               opcode flags from the IFD, answers each instruction with a
//               new PC and a stall of pseudo-random or fixed length, and
//               after a programmable number of transactions hands back
//               base_addr as the final PC and raises done.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stub_gen #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          MIN_STALL   = 1,
    parameter int          MAX_STALL   = 20,
    parameter int          MAX_TRANS   = 100000,
    parameter int          TRANS_WIDTH = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          FINAL_GAP   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             pc_mode,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [5:0]             pdp_mem_opcode,
    input  logic [21:0]            pdp_op7_opcode,
    output logic                   stall,
    output logic [ADDR_WIDTH-1:0]  PC_value,
    output logic                   done,
    output logic [TRANS_WIDTH-1:0] trans_count
);

    // FSM encoding
    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_ARM        = 3'd1;
    localparam logic [2:0] c_S_STALL      = 3'd2;
    localparam logic [2:0] c_S_FINAL_WAIT = 3'd3;
    localparam logic [2:0] c_S_GAP        = 3'd4;
    localparam logic [2:0] c_S_BASE       = 3'd5;
    localparam logic [2:0] c_S_DONE       = 3'd6;

    // Stall range; MAX_STALL <= 255 keeps everything in 8 bits.
    localparam logic [7:0] c_MIN_STALL = 8'(MIN_STALL);
    localparam logic [7:0] c_RANGE     = 8'(MAX_STALL - MIN_STALL + 1);
    localparam logic [TRANS_WIDTH-1:0] c_MAX_TRANS = TRANS_WIDTH'(MAX_TRANS);
    localparam int c_GAP_W = (FINAL_GAP > 0) ? $clog2(FINAL_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_FINAL_GAP = c_GAP_W'(FINAL_GAP);
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    logic [2:0]             r_state, w_state_nxt;
    logic [15:0]            r_lfsr, w_lfsr_nxt;
    logic [1:0]             r_mode, w_mode_nxt;
    logic [7:0]             r_scnt, w_scnt_nxt;
    logic [c_GAP_W-1:0]     r_gcnt, w_gcnt_nxt;
    logic                   r_stall, w_stall_nxt;
    logic [ADDR_WIDTH-1:0]  r_pc, w_pc_nxt;
    logic                   r_done, w_done_nxt;
    logic [TRANS_WIDTH-1:0] r_trans, w_trans_nxt;

    logic                   w_op_seen;
    logic [7:0]             w_stall_len;
    logic [ADDR_WIDTH-1:0]  w_cand;
    logic [ADDR_WIDTH-1:0]  w_pc_new;
    logic [TRANS_WIDTH-1:0] w_trans_inc;

    // Any decoded flag counts as an instruction; validity is not checked.
    assign w_op_seen   = (|pdp_mem_opcode) | (|pdp_op7_opcode);
    assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    assign w_stall_len = c_MIN_STALL + (r_lfsr[7:0] % c_RANGE);
    // Count saturates rather than wrapping.
    assign w_trans_inc = (r_trans == {TRANS_WIDTH{1'b1}}) ? r_trans : r_trans + 1'b1;

    // PC candidate for a normal transaction; base_addr is always skipped.
    always_comb begin
        case (r_mode)
            2'd1:    w_cand = r_pc + 1'b1;
            2'd2:    w_cand = r_pc;
            default: w_cand = r_lfsr[ADDR_WIDTH-1:0];
        endcase
        w_pc_new = (w_cand == base_addr) ? w_cand + 1'b1 : w_cand;
    end

    // State and datapath registers; reset overrides everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_mode  <= 2'd0;
            r_scnt  <= 8'd0;
            r_gcnt  <= '0;
            r_stall <= 1'b0;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_trans <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_mode  <= w_mode_nxt;
            r_scnt  <= w_scnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_stall <= w_stall_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
            r_trans <= w_trans_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:       if (w_op_seen) w_state_nxt = c_S_ARM;
            c_S_ARM:        w_state_nxt = c_S_STALL;
            c_S_STALL:      if (r_scnt == 8'd0)
                                w_state_nxt = (w_trans_inc == c_MAX_TRANS) ? c_S_FINAL_WAIT : c_S_IDLE;
            c_S_FINAL_WAIT: if (w_op_seen) w_state_nxt = c_S_GAP;
            c_S_GAP:        if (r_gcnt == '0) w_state_nxt = c_S_BASE;
            c_S_BASE:       w_state_nxt = c_S_DONE;
            c_S_DONE:       w_state_nxt = c_S_DONE;
            default:        w_state_nxt = c_S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_scnt_nxt  = r_scnt;
        w_gcnt_nxt  = r_gcnt;
        w_stall_nxt = r_stall;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        w_trans_nxt = r_trans;
        case (r_state)
            c_S_IDLE: begin
                // Mode 3 is reserved and behaves as random.
                if (w_op_seen) w_mode_nxt = (pc_mode == 2'd3) ? 2'd0 : pc_mode;
            end
            c_S_ARM: begin
                w_pc_nxt    = w_pc_new;
                w_stall_nxt = 1'b1;
                w_scnt_nxt  = w_stall_len - 8'd1;
            end
            c_S_STALL: begin
                if (r_scnt != 8'd0) begin
                    w_scnt_nxt = r_scnt - 8'd1;
                end else begin
                    w_stall_nxt = 1'b0;
                    w_trans_nxt = w_trans_inc;
                end
            end
            c_S_FINAL_WAIT: begin
                if (w_op_seen) w_gcnt_nxt = c_FINAL_GAP;
            end
            c_S_GAP: begin
                if (r_gcnt != '0) begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                end else begin
                    w_pc_nxt    = base_addr;
                    w_stall_nxt = 1'b1;
                end
            end
            c_S_BASE: begin
                w_stall_nxt = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall       = r_stall;
    assign PC_value    = r_pc;
    assign done        = r_done;
    assign trans_count = r_trans;

endmodule
`default_nettype wire

// File: tb/tb_exec_stub_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_stub_gen
// Description : Directed self-checking bench for exec_stub_gen using three
//               instances: fixed 3-cycle stall with two transactions,
//               fixed 1-cycle stall for the sequential sweep, and the
//               default 1..20 random stall range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stub_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Fixed-stall instance (L=3, two transactions before handoff)
    logic        rst_f, stall_f, done_f;
    logic [1:0]  mode_f;
    logic [11:0] base_f, pc_f;
    logic [5:0]  mem_f;
    logic [21:0] op7_f;
    logic [31:0] tc_f;
    // Sequential-sweep instance (L=1)
    logic        rst_s, stall_s, done_s;
    logic [1:0]  mode_s;
    logic [11:0] base_s, pc_s;
    logic [5:0]  mem_s;
    logic [21:0] op7_s;
    logic [31:0] tc_s;
    // Random-stall instance (defaults)
    logic        rst_r, stall_r, done_r;
    logic [1:0]  mode_r;
    logic [11:0] base_r, pc_r;
    logic [5:0]  mem_r;
    logic [21:0] op7_r;
    logic [31:0] tc_r;

    exec_stub_gen #(.MIN_STALL(3), .MAX_STALL(3), .MAX_TRANS(2)) u_fix (
        .clk(clk), .reset(rst_f), .pc_mode(mode_f), .base_addr(base_f),
        .pdp_mem_opcode(mem_f), .pdp_op7_opcode(op7_f),
        .stall(stall_f), .PC_value(pc_f), .done(done_f), .trans_count(tc_f));

    exec_stub_gen #(.MIN_STALL(1), .MAX_STALL(1)) u_seq (
        .clk(clk), .reset(rst_s), .pc_mode(mode_s), .base_addr(base_s),
        .pdp_mem_opcode(mem_s), .pdp_op7_opcode(op7_s),
        .stall(stall_s), .PC_value(pc_s), .done(done_s), .trans_count(tc_s));

    exec_stub_gen u_rand (
        .clk(clk), .reset(rst_r), .pc_mode(mode_r), .base_addr(base_r),
        .pdp_mem_opcode(mem_r), .pdp_op7_opcode(op7_r),
        .stall(stall_r), .PC_value(pc_r), .done(done_r), .trans_count(tc_r));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and land 1ns past the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          err, tmo, gap, n, len, minl, maxl, len_err, pc_err, gap_err;
    logic [11:0] prev, expc, after4, afterwrap, pc_cap;
    logic        got_wrap;

    initial begin
        rst_f = 1'b1; mode_f = 2'd0; base_f = '0; mem_f = '0; op7_f = '0;
        rst_s = 1'b1; mode_s = 2'd0; base_s = '0; mem_s = '0; op7_s = '0;
        rst_r = 1'b1; mode_r = 2'd0; base_r = '0; mem_r = '0; op7_r = '0;
        tmo = 0;
        step(2);
        chk("rst_stall", {31'd0, stall_f}, 32'd0);
        chk("rst_pc",    {20'd0, pc_f},    32'd0);
        chk("rst_done",  {31'd0, done_f},  32'd0);
        chk("rst_tc",    tc_f,             32'd0);
        rst_f = 1'b0; rst_s = 1'b0; rst_r = 1'b0;

        // ---- 500 idle cycles with no opcode flags
        err = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (stall_r !== 1'b0) err++;
        end
        chk("idle_stall", err, 0);
        chk("idle_tc", tc_r, 32'd0);
        chk("idle_pc", {20'd0, pc_r}, 32'd0);

        // ---- First transaction, fixed L=3, sequential mode, base 0
        mode_f = 2'd1; base_f = 12'd0;
        mem_f = 6'b000010;
        step(1);                               // edge A: IDLE sees op
        mem_f = '0;
        chk("arm_stall", {31'd0, stall_f}, 32'd0);
        step(1);                               // edge A+1
        chk("t1_stall_rise", {31'd0, stall_f}, 32'd1);
        chk("t1_pc", {20'd0, pc_f}, 32'd1);
        step(2);                               // edge A+3
        chk("t1_stall_hold", {31'd0, stall_f}, 32'd1);
        chk("t1_tc_during", tc_f, 32'd0);
        step(1);                               // edge A+4
        chk("t1_stall_fall", {31'd0, stall_f}, 32'd0);
        chk("t1_tc", tc_f, 32'd1);
        err = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (stall_f !== 1'b0) err++;
        end
        chk("t1_stays_idle", err, 0);
        chk("t1_tc_hold", tc_f, 32'd1);

        // ---- Reset in the middle of a stall
        mem_f = 6'b000001;
        step(1);
        mem_f = '0;
        step(2);                               // second stall cycle
        chk("mid_stall_high", {31'd0, stall_f}, 32'd1);
        rst_f = 1'b1;
        step(1);
        chk("mr_stall", {31'd0, stall_f}, 32'd0);
        chk("mr_pc",    {20'd0, pc_f},    32'd0);
        chk("mr_tc",    tc_f,             32'd0);
        chk("mr_done",  {31'd0, done_f},  32'd0);
        rst_f = 1'b0;
        op7_f = 22'h000001;
        step(1);
        op7_f = '0;
        chk("mr_lat_low", {31'd0, stall_f}, 32'd0);
        step(1);
        chk("mr_lat_stall", {31'd0, stall_f}, 32'd1);
        chk("mr_lat_pc", {20'd0, pc_f}, 32'd1);
        step(3);
        chk("mr_lat_fall", {31'd0, stall_f}, 32'd0);
        chk("mr_lat_tc", tc_f, 32'd1);

        // ---- Final handoff: two random transactions, then base address
        rst_f = 1'b1;
        step(1);
        rst_f = 1'b0; mode_f = 2'd0; base_f = 12'o0200;
        for (int k = 0; k < 2; k++) begin
            mem_f = 6'b100000;
            step(1);
            mem_f = '0;
            step(1);
            chk("fh_stall", {31'd0, stall_f}, 32'd1);
            chk("fh_pc_ne_base", {31'd0, (pc_f == base_f)}, 32'd0);
            step(3);
            chk("fh_fall", {31'd0, stall_f}, 32'd0);
        end
        chk("fh_tc", tc_f, 32'd2);
        mem_f = 6'b000100;
        step(1);                               // edge T
        mem_f = '0;
        err = 0;
        for (int i = 0; i < 5; i++) begin      // edges T+1..T+5
            step(1);
            if (stall_f !== 1'b0) err++;
        end
        chk("fh_gap_quiet", err, 0);
        step(1);                               // edge T+6
        chk("fh_base_stall", {31'd0, stall_f}, 32'd1);
        chk("fh_base_pc", {20'd0, pc_f}, 32'o0200);
        chk("fh_done_early", {31'd0, done_f}, 32'd0);
        step(1);
        chk("fh_base_fall", {31'd0, stall_f}, 32'd0);
        chk("fh_done", {31'd0, done_f}, 32'd1);
        mem_f = 6'b111111;
        err = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (stall_f !== 1'b0) err++;
        end
        mem_f = '0;
        chk("fh_ignore_ops", err, 0);
        chk("fh_done_hold", {31'd0, done_f}, 32'd1);
        chk("fh_tc_hold", tc_f, 32'd2);

        // ---- Sequential sweep with base skip and wraparound (L=1)
        mode_s = 2'd1; base_s = 12'o0005; mem_s = 6'b000010;
        prev = 12'd0; after4 = 12'hFFF; afterwrap = 12'hFFF;
        got_wrap = 1'b0; err = 0; gap_err = 0; n = 0;
        while (!got_wrap && n < 5000) begin
            gap = 0;
            while (stall_s !== 1'b1 && gap < 10) begin
                step(1);
                gap++;
            end
            if (stall_s !== 1'b1) begin
                tmo++;
                break;
            end
            if (n > 0 && gap != 2) gap_err++;
            expc = prev + 12'd1;
            if (expc == base_s) expc = expc + 12'd1;
            if (pc_s !== expc) err++;
            if (prev == 12'd4) after4 = pc_s;
            if (prev == 12'o7777) begin
                afterwrap = pc_s;
                got_wrap = 1'b1;
                mem_s = '0;
            end
            if (pc_s == 12'o7777) base_s = 12'd0;
            prev = pc_s;
            n++;
            step(1);
        end
        chk("seq_skip_base", {20'd0, after4}, 32'd6);
        chk("seq_wrap_skip", {20'd0, afterwrap}, 32'd1);
        chk("seq_errors", err, 0);
        chk("seq_b2b_gap", gap_err, 0);
        chk("seq_tc", tc_s, 32'd4095);
        chk("seq_done", {31'd0, done_s}, 32'd0);

        // ---- 1000 random transactions, L in [1,20]
        base_r = 12'o1234; mem_r = 6'b001000;
        len_err = 0; pc_err = 0; minl = 1000; maxl = 0;
        for (int t = 0; t < 1000; t++) begin
            gap = 0;
            while (stall_r !== 1'b1 && gap < 10) begin
                step(1);
                gap++;
            end
            if (stall_r !== 1'b1) begin
                tmo++;
                break;
            end
            pc_cap = pc_r;
            len = 0;
            while (stall_r === 1'b1 && len < 300) begin
                step(1);
                len++;
            end
            if (t == 999) mem_r = '0;
            if (len < 1 || len > 20) len_err++;
            if (pc_cap == base_r) pc_err++;
            if (len < minl) minl = len;
            if (len > maxl) maxl = len;
        end
        chk("rnd_len_range", len_err, 0);
        chk("rnd_pc_ne_base", pc_err, 0);
        chk("rnd_len_varies", {31'd0, (minl < maxl)}, 32'd1);
        chk("rnd_tc", tc_r, 32'd1000);
        step(5);
        chk("rnd_quiet", {31'd0, stall_r}, 32'd0);
        chk("rnd_tc_hold", tc_r, 32'd1000);
        chk("rnd_done", {31'd0, done_r}, 32'd0);

        chk("timeouts", tmo, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
